// File: rtl/key_schedule_engine_pkg.sv
// Shared constants and helpers for the AES key schedule engine: schedule sizing,
// FSM encodings, round-constant generation and the AES S-box.
package key_schedule_engine_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_EXPAND = 2'd1;
    localparam logic [1:0] ST_EMIT   = 2'd2;

    localparam logic [7:0] RCON_INIT = 8'h01;
    localparam logic [7:0] RCON_POLY = 8'h1b;

    // Forward AES S-box, entry 0 in the leftmost byte
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic int unsigned calc_nk(input int unsigned key_bits);
        return key_bits / 32;
    endfunction

    function automatic int unsigned calc_nr(input int unsigned key_bits);
        return calc_nk(key_bits) + 6;
    endfunction

    function automatic int unsigned calc_nw(input int unsigned key_bits);
        return 4 * (calc_nr(key_bits) + 1);
    endfunction

    function automatic logic [7:0] key_sub_byte(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/key_word_transform.sv
// Combinational schedule-word transform: optional RotWord, SubWord and round-constant XOR.
// With i_SubEn low the word passes through untouched.
module key_word_transform
    import key_schedule_engine_pkg::*;
(
    input  logic [31:0] i_Word,
    input  logic        i_RotEn,
    input  logic        i_SubEn,
    input  logic [7:0]  i_Rcon,
    output logic [31:0] o_Word_c
);

    logic [31:0] w_rot;
    logic [31:0] w_sub;

    always_comb begin
        w_rot = i_RotEn ? {i_Word[23:0], i_Word[31:24]} : i_Word;
        for (int b = 0; b < 4; b++) begin
            w_sub[8*b +: 8] = key_sub_byte(w_rot[8*b +: 8]);
        end
        o_Word_c = i_SubEn ? (w_sub ^ {i_Rcon, 24'h000000}) : i_Word;
    end

endmodule

// File: rtl/key_schedule_engine.sv
// Sequential AES key expansion (one word per clock) into a local schedule buffer,
// then streams round keys forward or reverse over a valid/ready port; replay skips expansion.
module key_schedule_engine
    import key_schedule_engine_pkg::*;
#(
    parameter int unsigned KEY_BITS = 128
)
(
    input  logic                i_Clk,
    input  logic                i_Rst,
    input  logic                i_Start,
    input  logic                i_Replay,
    input  logic                i_fDec,
    input  logic [KEY_BITS-1:0] i_Key,
    input  logic                i_Ready,
    output logic                o_Busy,
    output logic                o_KeyValid,
    output logic                o_Valid,
    output logic [127:0]        o_RoundKey,
    output logic [3:0]          o_RoundIdx,
    output logic                o_Last
);

    localparam int unsigned NK = calc_nk(KEY_BITS);
    localparam int unsigned NR = calc_nr(KEY_BITS);
    localparam int unsigned NW = calc_nw(KEY_BITS);
    localparam int unsigned IW = $clog2(NW);

    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
        $error("key_schedule_engine: KEY_BITS must be 128, 192 or 256");
    end

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [31:0]   r_w [NW];
    logic [IW-1:0] r_widx;
    logic [2:0]    r_kpos;
    logic [7:0]    r_rcon;
    logic [3:0]    r_round;
    logic          r_dec;

    logic          w_replay;
    logic          w_done;
    logic          w_load;
    logic          w_last_word;
    logic          w_rot_en;
    logic          w_sub_en;
    logic [7:0]    w_rcon_in;
    logic [31:0]   w_prev;
    logic [31:0]   w_back;
    logic [31:0]   w_t;
    logic [31:0]   w_new;
    logic [3:0]    w_end_round;
    logic [IW-1:0] w_base;

    assign w_replay    = i_Replay && !i_Start && o_KeyValid;
    assign w_done      = (r_state == ST_EMIT) && o_Valid && i_Ready && o_Last;
    assign w_load      = (r_state == ST_EMIT) && (!o_Valid || (i_Ready && !o_Last));
    assign w_last_word = (r_widx == IW'(NW - 1));

    // r_kpos tracks i % Nk, so no divider is needed
    assign w_rot_en    = (r_kpos == 3'd0);
    assign w_sub_en    = w_rot_en || (NK == 8 && r_kpos == 3'd4);
    assign w_rcon_in   = w_rot_en ? r_rcon : 8'h00;
    assign w_prev      = r_w[r_widx - IW'(1)];
    assign w_back      = r_w[r_widx - IW'(NK)];
    assign w_new       = w_back ^ w_t;
    assign w_end_round = r_dec ? 4'd0 : 4'(NR);
    assign w_base      = IW'({r_round, 2'b00});

    key_word_transform u_kwt (
        .i_Word   (w_prev),
        .i_RotEn  (w_rot_en),
        .i_SubEn  (w_sub_en),
        .i_Rcon   (w_rcon_in),
        .o_Word_c (w_t)
    );

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_Start) begin
                    w_state_nxt = ST_EXPAND;
                end else if (w_replay) begin
                    w_state_nxt = ST_EMIT;
                end
            end
            ST_EXPAND: if (w_last_word) w_state_nxt = ST_EMIT;
            ST_EMIT:   if (w_done) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Schedule buffer; validity is tracked by o_KeyValid, so no reset is needed here
    always_ff @(posedge i_Clk) begin
        if (r_state == ST_IDLE && i_Start) begin
            for (int j = 0; j < NK; j++) begin
                r_w[j] <= i_Key[KEY_BITS - 1 - 32*j -: 32];
            end
        end else if (r_state == ST_EXPAND) begin
            r_w[r_widx] <= w_new;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            o_Busy     <= 1'b0;
            o_KeyValid <= 1'b0;
            o_Valid    <= 1'b0;
            o_RoundKey <= '0;
            o_RoundIdx <= '0;
            o_Last     <= 1'b0;
            r_widx     <= '0;
            r_kpos     <= '0;
            r_rcon     <= RCON_INIT;
            r_round    <= '0;
            r_dec      <= 1'b0;
        end else begin
            o_Busy <= (w_state_nxt != ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    if (i_Start) begin
                        r_widx     <= IW'(NK);
                        r_kpos     <= '0;
                        r_rcon     <= RCON_INIT;
                        o_KeyValid <= 1'b0;
                        r_dec      <= i_fDec;
                    end else if (w_replay) begin
                        r_dec   <= i_fDec;
                        r_round <= i_fDec ? 4'(NR) : 4'd0;
                    end
                end
                ST_EXPAND: begin
                    r_widx <= r_widx + IW'(1);
                    r_kpos <= (r_kpos == 3'(NK - 1)) ? 3'd0 : r_kpos + 3'd1;
                    if (w_rot_en) r_rcon <= xtime(r_rcon);
                    if (w_last_word) begin
                        o_KeyValid <= 1'b1;
                        r_round    <= r_dec ? 4'(NR) : 4'd0;
                    end
                end
                ST_EMIT: begin
                    if (w_done) begin
                        o_Valid <= 1'b0;
                        o_Last  <= 1'b0;
                    end else if (w_load) begin
                        // r_round is the next key to present; it parks at the end round
                        o_Valid    <= 1'b1;
                        o_RoundKey <= {r_w[w_base], r_w[w_base + IW'(1)],
                                       r_w[w_base + IW'(2)], r_w[w_base + IW'(3)]};
                        o_RoundIdx <= r_round;
                        o_Last     <= (r_round == w_end_round);
                        if (r_round != w_end_round) begin
                            r_round <= r_dec ? r_round - 4'd1 : r_round + 4'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
